vga_timing_gen: RTL and testbench

//  Source end of the pixel-scan interface consumed by every VGA overlay controller.

---
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-scan bundle from the VGA timing source to its overlay controllers.
// The timing generator drives through master; consumers attach through slave.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync, frame_start, frame_count
  );

  modport slave (
    input  pix_en, hCount, vCount, bright, hSync, vSync, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan timing source: divides clk down to a pixel tick and runs the h/v counters.
// Every output is registered from next-state counts, so all of them change on the same edge.
module vga_timing_gen #(
  parameter int CLK_DIV        = 4,
  parameter int H_TOTAL        = 800,
  parameter int H_SYNC_END     = 96,
  parameter int H_BRIGHT_START = 144,
  parameter int H_BRIGHT_END   = 784,
  parameter int V_TOTAL        = 525,
  parameter int V_SYNC_END     = 2,
  parameter int V_BRIGHT_START = 35,
  parameter int V_BRIGHT_END   = 515
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0]       VS_END   = 10'(V_SYNC_END);
  localparam logic [9:0]       HB_START = 10'(H_BRIGHT_START);
  localparam logic [9:0]       HB_END   = 10'(H_BRIGHT_END);
  localparam logic [9:0]       VB_START = 10'(V_BRIGHT_START);
  localparam logic [9:0]       VB_END   = 10'(V_BRIGHT_END);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_count_q, h_count_d;
  logic [9:0]       v_count_q, v_count_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             pix_en_q, pix_en_d;
  logic             frame_start_q, frame_start_d;
  logic             bright_q, bright_d;
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = tick && (h_count_q == H_LAST);
  assign v_wrap = h_wrap && (v_count_q == V_LAST);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    div_d         = tick ? '0 : div_q + 1'b1;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;

    if (tick)   h_count_d     = h_wrap ? '0 : h_count_q + 10'd1;
    if (h_wrap) v_count_d     = v_wrap ? '0 : v_count_q + 10'd1;
    if (v_wrap) frame_count_d = frame_count_q + 8'd1;

    // pix_en and frame_start mark the clk in which the new counts are first visible.
    pix_en_d      = tick;
    frame_start_d = v_wrap;

    bright_d = (h_count_d >= HB_START) && (h_count_d < HB_END) &&
               (v_count_d >= VB_START) && (v_count_d < VB_END);
    h_sync_d = !(h_count_d < HS_END);
    v_sync_d = !(v_count_d < VS_END);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      bright_q      <= 1'b0;
      // Count 0 lies inside both sync pulses, so the syncs reset asserted (low).
      h_sync_q      <= 1'b0;
      v_sync_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      bright_q      <= bright_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hCount      = h_count_q;
  assign vga.vCount      = v_count_q;
  assign vga.bright      = bright_q;
  assign vga.hSync       = h_sync_q;
  assign vga.vSync       = v_sync_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 10x6 raster: a closed-form scan model checked every
// cycle, plus directed literal probes at the line, bright, frame and frame-counter boundaries.
module tb_vga_timing_gen;

  localparam int CD  = 4;
  localparam int HT  = 10;
  localparam int HSE = 2;
  localparam int HBS = 3;
  localparam int HBE = 8;
  localparam int VT  = 6;
  localparam int VSE = 1;
  localparam int VBS = 2;
  localparam int VBE = 5;
  localparam int FRAME_CLKS = HT * VT * CD;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       bright;
    logic       h_sync;
    logic       v_sync;
    logic       frame_start;
    logic [7:0] frame_count;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC_END(HSE), .H_BRIGHT_START(HBS), .H_BRIGHT_END(HBE),
    .V_TOTAL(VT), .V_SYNC_END(VSE), .V_BRIGHT_START(VBS), .V_BRIGHT_END(VBE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  // Scan position after n edges, straight from the raster definition.
  function automatic outs_t model(input int n);
    outs_t o;
    int ticks, p, h, v;
    ticks         = n / CD;
    p             = ticks % (HT * VT);
    h             = p % HT;
    v             = p / HT;
    o.pix_en      = (n > 0) && (n % CD == 0);
    o.h           = 10'(h);
    o.v           = 10'(v);
    o.bright      = (h >= HBS) && (h < HBE) && (v >= VBS) && (v < VBE);
    o.h_sync      = !(h < HSE);
    o.v_sync      = !(v < VSE);
    o.frame_start = o.pix_en && (p == 0);
    o.frame_count = 8'((ticks / (HT * VT)) % 256);
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      if (failures >= 50) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  function automatic outs_t actual();
    outs_t a;
    a = {vif.pix_en, vif.hCount, vif.vCount, vif.bright, vif.hSync, vif.vSync,
         vif.frame_start, vif.frame_count};
    return a;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) check($sformatf("cycle_model@edge%0d", edges), 64'(actual()), 64'(model(edges)));
  end

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edges < n && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != n) check("wait_edge_bound", 64'(edges), 64'(n));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pix_en"},      64'(vif.pix_en),      64'd0);
    check({tag, "_hCount"},      64'(vif.hCount),      64'd0);
    check({tag, "_vCount"},      64'(vif.vCount),      64'd0);
    check({tag, "_bright"},      64'(vif.bright),      64'd0);
    check({tag, "_hSync"},       64'(vif.hSync),       64'd0);
    check({tag, "_vSync"},       64'(vif.vSync),       64'd0);
    check({tag, "_frame_start"}, 64'(vif.frame_start), 64'd0);
    check({tag, "_frame_count"}, 64'(vif.frame_count), 64'd0);
  endtask

  initial begin
    int bright_cnt, hs_low_cnt, vs_low_cnt;

    // Power-up reset, held for 5 clks.
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // First ticks, first line wrap, sync width and dark top lines.
    bright_cnt = 0;
    hs_low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (vif.bright) bright_cnt++;
      if (i >= 40 && !vif.hSync) hs_low_cnt++;
      case (i)
        3: begin
          check("edge3_pix_en", 64'(vif.pix_en), 64'd0);
          check("edge3_hCount", 64'(vif.hCount), 64'd0);
        end
        4: begin
          check("edge4_pix_en", 64'(vif.pix_en), 64'd1);
          check("edge4_hCount", 64'(vif.hCount), 64'd1);
          check("edge4_hSync",  64'(vif.hSync),  64'd0);
        end
        8: begin
          check("edge8_hCount", 64'(vif.hCount), 64'd2);
          check("edge8_hSync",  64'(vif.hSync),  64'd1);
        end
        39: begin
          check("edge39_hCount", 64'(vif.hCount), 64'd9);
          check("edge39_vCount", 64'(vif.vCount), 64'd0);
        end
        40: begin
          check("edge40_hCount", 64'(vif.hCount), 64'd0);
          check("edge40_vCount", 64'(vif.vCount), 64'd1);
        end
        default: ;
      endcase
      @(negedge clk);
    end
    check("bright_top_lines", 64'(bright_cnt), 64'd0);
    check("hsync_low_clks",   64'(hs_low_cnt), 64'(HSE * CD));

    // Bright window edges: (2,2)->(3,2) rises, (7,4)->(8,4) falls.
    wait_edge(91);
    check("bright_before_rise", 64'(vif.bright), 64'd0);
    @(negedge clk);
    check("bright_rise",        64'(vif.bright), 64'd1);
    check("bright_rise_hCount", 64'(vif.hCount), 64'd3);
    wait_edge(191);
    check("bright_before_fall", 64'(vif.bright), 64'd1);
    @(negedge clk);
    check("bright_fall",        64'(vif.bright), 64'd0);
    check("bright_fall_vCount", 64'(vif.vCount), 64'd4);

    // Frame wrap (9,5)->(0,0) and vSync width over the following frame.
    wait_edge(FRAME_CLKS - 1);
    vs_low_cnt = 0;
    for (int i = FRAME_CLKS - 1; i < 2 * FRAME_CLKS; i++) begin
      if (i >= FRAME_CLKS && !vif.vSync) vs_low_cnt++;
      case (i)
        FRAME_CLKS - 1: begin
          check("pre_wrap_hCount",      64'(vif.hCount),      64'd9);
          check("pre_wrap_vCount",      64'(vif.vCount),      64'd5);
          check("pre_wrap_frame_start", 64'(vif.frame_start), 64'd0);
        end
        FRAME_CLKS: begin
          check("wrap_hCount",      64'(vif.hCount),      64'd0);
          check("wrap_vCount",      64'(vif.vCount),      64'd0);
          check("wrap_frame_start", 64'(vif.frame_start), 64'd1);
          check("wrap_frame_count", 64'(vif.frame_count), 64'd1);
        end
        FRAME_CLKS + 1:
          check("post_wrap_frame_start", 64'(vif.frame_start), 64'd0);
        default: ;
      endcase
      @(negedge clk);
    end
    check("vsync_low_clks", 64'(vs_low_cnt), 64'(VSE * HT * CD));

    // Mid-frame reset between clock edges must act without a clk edge.
    wait_edge(575);
    check("mid_hCount", 64'(vif.hCount), 64'd3);
    check("mid_vCount", 64'(vif.vCount), 64'd2);
    #1 rst = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_edge(4);
    check("restart_hCount",      64'(vif.hCount),      64'd1);
    check("restart_vCount",      64'(vif.vCount),      64'd0);
    check("restart_frame_count", 64'(vif.frame_count), 64'd0);

    // 256 frames: frame_count 255 -> 0 together with frame_start.
    wait_edge(256 * FRAME_CLKS - 1);
    check("fc_before_wrap", 64'(vif.frame_count), 64'd255);
    @(negedge clk);
    check("fc_wrap",             64'(vif.frame_count), 64'd0);
    check("fc_wrap_frame_start", 64'(vif.frame_start), 64'd1);
    check("fc_wrap_hCount",      64'(vif.hCount),      64'd0);
    @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
